// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 32x64 register file with writeback bypass, immediate
// select for operand B, and a registered output stage with stall/flush.
module operand_fetch_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InValid,
    input  logic [4:0]  RA,
    input  logic [4:0]  RB,
    input  logic        ImmEn,
    input  logic [63:0] Imm,
    input  logic [3:0]  ALUCtrlIn,
    input  logic        RegWr,
    input  logic [4:0]  RW,
    input  logic [63:0] BusW,
    input  logic        Stall,
    input  logic        Flush,
    output logic        OutValid,
    output logic [63:0] BusA,
    output logic [63:0] BusB,
    output logic [3:0]  ALUCtrl
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic [63:0] regs_q [0:31];

    logic        out_valid_q, out_valid_d;
    logic [63:0] bus_a_q,     bus_a_d;
    logic [63:0] bus_b_q,     bus_b_d;
    logic [3:0]  alu_ctrl_q,  alu_ctrl_d;

    logic        wr_en;
    logic [63:0] opnd_a;
    logic [63:0] opnd_b_reg;
    logic [63:0] opnd_b;

    assign wr_en = RegWr && (RW != ZERO_REG);

    // Register file: reset clears every entry; X31 is never written.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i[4:0]] <= '0;
            end
        end else if (wr_en) begin
            regs_q[RW] <= BusW;
        end
    end

    // Operand read with X31-as-zero and same-cycle writeback bypass.
    always_comb begin
        opnd_a     = '0;
        opnd_b_reg = '0;
        if (RA != ZERO_REG) begin
            opnd_a = (wr_en && (RW == RA)) ? BusW : regs_q[RA];
        end
        if (RB != ZERO_REG) begin
            opnd_b_reg = (wr_en && (RW == RB)) ? BusW : regs_q[RB];
        end
        opnd_b = ImmEn ? Imm : opnd_b_reg;
    end

    // Output stage next state: Flush > Stall > load; an invalid load holds data.
    always_comb begin
        out_valid_d = out_valid_q;
        bus_a_d     = bus_a_q;
        bus_b_d     = bus_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        if (Flush) begin
            out_valid_d = 1'b0;
            bus_a_d     = '0;
            bus_b_d     = '0;
            alu_ctrl_d  = '0;
        end else if (!Stall) begin
            out_valid_d = InValid;
            if (InValid) begin
                bus_a_d    = opnd_a;
                bus_b_d    = opnd_b;
                alu_ctrl_d = ALUCtrlIn;
            end
        end
    end

    // Output stage registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid_q <= 1'b0;
            bus_a_q     <= '0;
            bus_b_q     <= '0;
            alu_ctrl_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bus_a_q     <= bus_a_d;
            bus_b_q     <= bus_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
        end
    end

    assign OutValid = out_valid_q;
    assign BusA     = bus_a_q;
    assign BusB     = bus_b_q;
    assign ALUCtrl  = alu_ctrl_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: a driver applies one cycle of
// stimulus, predicts the output stage after the edge and queues it; a monitor
// compares the queued prediction against the DUT on the following falling edge.
module tb_operand_fetch_stage;

    typedef struct packed {
        logic        v;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  c;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        InValid = 1'b0;
    logic [4:0]  RA = '0;
    logic [4:0]  RB = '0;
    logic        ImmEn = 1'b0;
    logic [63:0] Imm = '0;
    logic [3:0]  ALUCtrlIn = '0;
    logic        RegWr = 1'b0;
    logic [4:0]  RW = '0;
    logic [63:0] BusW = '0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        OutValid;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [3:0]  ALUCtrl;

    operand_fetch_stage dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .RA(RA), .RB(RB),
        .ImmEn(ImmEn), .Imm(Imm), .ALUCtrlIn(ALUCtrlIn), .RegWr(RegWr),
        .RW(RW), .BusW(BusW), .Stall(Stall), .Flush(Flush),
        .OutValid(OutValid), .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    logic [63:0] m_regs [32];
    exp_t        m_out;
    exp_t        sb_q [$];
    exp_t        mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: one prediction per clock edge, compared on the falling edge.
    always @(negedge Clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if ({OutValid, BusA, BusB, ALUCtrl} !== mon_e) begin
                n_fail++;
                $display("FAIL out_stage t=%0t: got v=%0b a=%h b=%h c=%h, expected v=%0b a=%h b=%h c=%h",
                         $time, OutValid, BusA, BusB, ALUCtrl, mon_e.v, mon_e.a, mon_e.b, mon_e.c);
            end
        end
    end

    function automatic logic [63:0] read_port(input logic [4:0] idx, input logic wr,
                                              input logic [4:0] widx, input logic [63:0] wdata);
        if (idx == 5'd31) return 64'd0;
        if (wr && widx == idx) return wdata;
        return m_regs[idx];
    endfunction

    task automatic step(input logic rst, input logic inv, input logic [4:0] ra,
                        input logic [4:0] rb, input logic immen, input logic [63:0] imm,
                        input logic [3:0] ctrl, input logic regwr, input logic [4:0] rw,
                        input logic [63:0] busw, input logic stall, input logic flush);
        logic [63:0] a, b;
        Rst = rst; InValid = inv; RA = ra; RB = rb; ImmEn = immen; Imm = imm;
        ALUCtrlIn = ctrl; RegWr = regwr; RW = rw; BusW = busw; Stall = stall; Flush = flush;
        @(posedge Clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_out = '0;
        end else begin
            a = read_port(ra, regwr, rw, busw);
            b = immen ? imm : read_port(rb, regwr, rw, busw);
            if (flush)       m_out = '0;
            else if (stall)  m_out = m_out;
            else if (inv)    m_out = '{v: 1'b1, a: a, b: b, c: ctrl};
            else             m_out.v = 1'b0;
            if (regwr && rw != 5'd31) m_regs[rw] = busw;
        end
        sb_q.push_back(m_out);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [4:0] rw, input logic [63:0] d);
        step(0, 0, 0, 0, 0, 0, 0, 1, rw, d, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_out = '0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Reset clears preloaded register
        wr(5, 64'hAA);
        step(1, 1, 5, 0, 0, 0, 4'h3, 1, 5, 64'h55, 1, 1);
        step(0, 1, 5, 0, 0, 0, 4'h1, 0, 0, 0, 0, 0);
        idle();

        // Write then read
        wr(3, 64'h1234);
        step(0, 1, 3, 3, 0, 0, 4'h2, 0, 0, 0, 0, 0);

        // Same-cycle bypass, then read back stored value
        step(0, 1, 7, 0, 0, 0, 4'h0, 1, 7, 64'hBEEF, 0, 0);
        step(0, 1, 7, 7, 0, 0, 4'h1, 0, 0, 0, 0, 0);

        // X31 writes discarded; bypass to X31 reads zero
        wr(31, 64'hFFFF);
        step(0, 1, 31, 31, 0, 0, 4'h7, 0, 0, 0, 0, 0);
        step(0, 1, 31, 31, 0, 0, 4'h6, 1, 31, 64'hFFFF, 0, 0);

        // Stall holds across new requests and writebacks; flush overrides stall
        wr(1, 64'h9);
        step(0, 1, 1, 1, 0, 0, 4'h5, 0, 0, 0, 0, 0);
        step(0, 1, 2, 3, 0, 0, 4'h8, 1, 1, 64'h77, 1, 0);
        step(0, 1, 3, 3, 1, 64'h5, 4'hF, 0, 0, 0, 1, 0);
        step(0, 0, 4, 4, 0, 0, 4'h9, 1, 4, 64'h44, 1, 0);
        step(0, 1, 1, 1, 0, 0, 4'h2, 0, 0, 0, 1, 1);

        // Immediate select, unusual ALU codes, invalid load holds data
        wr(2, 64'hAB7);
        step(0, 1, 2, 9, 1, 64'h3, 4'h4, 0, 0, 0, 0, 0);
        step(0, 1, 2, 2, 0, 0, 4'hD, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic        r_rst, r_inv, r_imme, r_wr, r_st, r_fl;
            logic [4:0]  r_ra, r_rb, r_rw;
            logic [63:0] r_imm, r_w;
            logic [3:0]  r_c;
            r_rst  = ($urandom_range(0, 99) < 2);
            r_inv  = ($urandom_range(0, 99) < 70);
            r_imme = ($urandom_range(0, 99) < 25);
            r_wr   = ($urandom_range(0, 99) < 55);
            r_st   = ($urandom_range(0, 99) < 20);
            r_fl   = ($urandom_range(0, 99) < 8);
            r_ra   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            r_rb   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            r_rw   = ($urandom_range(0, 3) == 0) ? r_ra : 5'($urandom_range(0, 31));
            r_imm  = {$urandom, $urandom};
            r_w    = {$urandom, $urandom};
            r_c    = 4'($urandom_range(0, 15));
            step(r_rst, r_inv, r_ra, r_rb, r_imme, r_imm, r_c, r_wr, r_rw, r_w, r_st, r_fl);
        end

        // Read every register back to expose stored contents
        for (int k = 0; k < 32; k++) begin
            step(0, 1, 5'(k), 5'(31 - k), 0, 0, 4'(k), 0, 0, 0, 0, 0);
        end

        idle();
        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL provide port: Clk  input  1  the single clock, all state updates on rising edge.
REQ-002 SHALL provide port: Rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL provide port: InValid  input  1  issue request, qualifies RA/RB/ImmEn/Imm/ALUCtrlIn.
REQ-004 SHALL provide port: RA  input  5  source register index for BusA.
REQ-005 SHALL provide port: RB  input  5  source register index for BusB.
REQ-006 SHALL provide port: ImmEn  input  1  select Imm instead of register RB for BusB.
REQ-007 SHALL provide port: Imm  input  64  immediate operand.
REQ-008 SHALL provide port: ALUCtrlIn  input  4  ALU operation code, passed through to the ALU.
REQ-009 SHALL provide port: RegWr  input  1  writeback enable.
REQ-010 SHALL provide port: RW  input  5  writeback register index.
REQ-011 SHALL provide port: BusW  input  64  writeback data, taken from the ALU result path.
REQ-012 SHALL provide port: Stall  input  1  hold the output stage.
REQ-013 SHALL provide port: Flush  input  1  kill the operation in the output stage.
REQ-014 SHALL provide port: OutValid  output  1  BusA/BusB/ALUCtrl hold a live operation.
REQ-015 SHALL provide port: BusA  output  64  registered ALU operand A.
REQ-016 SHALL provide port: BusB  output  64  registered ALU operand B.
REQ-017 SHALL provide port: ALUCtrl  output  4  registered ALU operation code.

Function
REQ-018 SHALL contain a 32 x 64-bit register file, X0..X31.
REQ-019 SHALL return 0 for any read of X31; writes with RW=31 SHALL be discarded.
REQ-020 SHALL write BusW into X[RW] at the rising edge when RegWr=1, RW!=31, Rst=0, regardless of Stall or Flush.
REQ-021 SHALL read both ports combinationally from the array in the same cycle as the request.
REQ-022 SHALL bypass: if RegWr=1, RW=RA, RA!=31, operand A SHALL be BusW; same rule for RB on operand B.
REQ-023 SHALL select operand B = Imm when ImmEn=1, else the (bypassed) read of RB.
REQ-024 SHALL update the output stage at each rising edge with priority Rst > Flush > Stall > load.
REQ-025 Flush (Rst=0): OutValid<=0, BusA/BusB/ALUCtrl<=0; Flush SHALL override Stall.
REQ-026 Stall (Rst=0, Flush=0): OutValid, BusA, BusB, ALUCtrl SHALL hold; held operands SHALL NOT be refreshed by later writebacks.
REQ-027 Load with InValid=1: OutValid<=1, BusA<=operand A, BusB<=operand B, ALUCtrl<=ALUCtrlIn.
REQ-028 Load with InValid=0: OutValid<=0, BusA/BusB/ALUCtrl SHALL hold.
REQ-029 Latency SHALL be exactly one cycle from accepted request to OutValid=1.
REQ-030 SHALL pass ALUCtrlIn unmodified, including codes outside {0,1,2,3,4,6,7}.
REQ-031 Stall while InValid=1 SHALL drop the request; upstream SHALL re-present it.

Reset
REQ-032 Rst=1 at an edge SHALL clear all 32 registers and set OutValid=0, BusA=0, BusB=0, ALUCtrl=0.
REQ-033 Rst SHALL override RegWr, Stall, Flush and InValid in the same cycle; no write SHALL occur.
REQ-034 Rst asserted mid-operation SHALL discard the in-flight operation; first request SHALL be accepted on the edge after Rst deasserts.

Verification
REQ-035 Reset: preload X5=0xAA, Rst=1 one cycle, then RA=5 InValid=1 -> next edge BusA=0x0, OutValid=1, prior to that OutValid=0.
REQ-036 Write then read: RegWr=1 RW=3 BusW=0x1234; next cycle RA=3 RB=3 ALUCtrlIn=0x2 InValid=1 -> BusA=BusB=0x1234, ALUCtrl=0x2, OutValid=1.
REQ-037 Bypass: same cycle RegWr=1 RW=7 BusW=0xBEEF, RA=7 InValid=1 -> next edge BusA=0xBEEF and X7=0xBEEF.
REQ-038 X31: RegWr=1 RW=31 BusW=0xFFFF, then RA=31 RB=31 -> BusA=BusB=0x0; same-cycle bypass to RA=31 SHALL also give 0x0.
REQ-039 Stall/Flush: load BusA=0x9 OutValid=1, assert Stall 3 cycles with new requests -> outputs unchanged; Stall=1 Flush=1 -> OutValid=0, BusA=0x0.
REQ-040 Immediate: X2=0xAB7, RA=2 ImmEn=1 Imm=0x3 ALUCtrlIn=0x4 -> BusA=0xAB7, BusB=0x3, ALUCtrl=0x4.
